// File: rtl/pattern_source_pkg.sv
// Shared types and default sizing for the pattern_source run-length player.
package pattern_source_pkg;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    typedef struct packed {
        logic                 pat_bit;
        logic [DEF_CNT_W-1:0] len;
    } run_entry_t;

endpackage

// File: rtl/pattern_run_fifo.sv
// Synchronous run-entry FIFO; rst_i is active-low and clears only the pointers and count.
module pattern_run_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pattern_source.sv
// Run-length pattern player with optional prediction scoring.
// Define PATTERN_SOURCE_SCORE_EN to build the saturating miss counter; otherwise miss_cnt is 0.
module pattern_source
    import pattern_source_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [CNT_W-1:0] in_len,
    input  logic             enable,
    input  logic             predicted_pattern,
    output logic             actual_pattern,
    output logic             pat_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int EW = CNT_W + 1;

    logic [EW-1:0]    head;
    logic             head_bit;
    logic [CNT_W-1:0] head_len;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             run_end;
    logic             load_run;

    state_e           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic             pat_q;

    pattern_run_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst),
        .push_i  (in_valid),
        .pop_i   (fifo_pop),
        .wdata_i ({in_bit, in_len}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_bit = head[CNT_W];
    assign head_len = head[CNT_W-1:0];

    // The last bit of a run pops the next entry in the same cycle, so runs play back to back.
    assign run_end  = (state_q == PLAY) && enable && (rem_q == CNT_W'(1));
    assign fifo_pop = enable && !fifo_empty && ((state_q == IDLE) || run_end);
    assign load_run = fifo_pop && (head_len != '0);

    assign in_ready       = !fifo_full;
    assign pat_valid      = (state_q == PLAY) && enable;
    assign busy           = (state_q != IDLE) || !fifo_empty;
    assign actual_pattern = pat_q;
    assign bit_cnt        = bit_cnt_q;
    assign run_cnt        = run_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            pat_q     <= 1'b0;
            bit_cnt_q <= '0;
            run_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_run) begin
                        state_q <= PLAY;
                        pat_q   <= head_bit;
                        rem_q   <= head_len;
                    end
                end
                PLAY: begin
                    if (enable) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        rem_q     <= rem_q - 1'b1;
                        if (run_end) begin
                            run_cnt_q <= run_cnt_q + 1'b1;
                            // A zero-length successor drops to IDLE, leaving a one-cycle gap.
                            if (load_run) begin
                                pat_q <= head_bit;
                                rem_q <= head_len;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PATTERN_SOURCE_SCORE_EN
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (pat_valid && (predicted_pattern != pat_q)) miss_cnt_d = sat_inc(miss_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) miss_cnt_q <= '0;
        else      miss_cnt_q <= miss_cnt_d;
    end

    assign miss_cnt = miss_cnt_q;
`else
    logic unused_pred;
    assign unused_pred = predicted_pattern;
    assign miss_cnt    = '0;
`endif

endmodule

// File: tb/tb_pattern_source.sv
// Directed self-checking bench for pattern_source; expectations follow PATTERN_SOURCE_SCORE_EN.
module tb_pattern_source;
    import pattern_source_pkg::*;

    localparam int CNT_W = 8;

`ifdef PATTERN_SOURCE_SCORE_EN
    localparam int EXP_MISS_S4 = 3;
    localparam int EXP_MISS_S5 = 255;
`else
    localparam int EXP_MISS_S4 = 0;
    localparam int EXP_MISS_S5 = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_bit = 1'b0;
    logic [CNT_W-1:0] in_len = '0;
    logic             enable = 1'b1;
    logic             predicted_pattern = 1'b0;
    logic             actual_pattern;
    logic             pat_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pattern_source #(.CNT_W(CNT_W), .FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_bit            (in_bit),
        .in_len            (in_len),
        .enable            (enable),
        .predicted_pattern (predicted_pattern),
        .actual_pattern    (actual_pattern),
        .pat_valid         (pat_valid),
        .busy              (busy),
        .bit_cnt           (bit_cnt),
        .run_cnt           (run_cnt),
        .miss_cnt          (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        enable   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one entry from a negedge and returns at the negedge after it was accepted.
    task automatic push(input logic b, input logic [CNT_W-1:0] l);
        run_entry_t e;
        int n;
        e        = '{pat_bit: b, len: l};
        in_bit   = e.pat_bit;
        in_len   = e.len;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", pat_valid, 0);
        check("rst_pat",   actual_pattern, 0);
        check("rst_busy",  busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_bits",  bit_cnt, 0);
        check("rst_runs",  run_cnt, 0);
        check("rst_miss",  miss_cnt, 0);

        // Two contiguous runs {0,4},{1,4}
        push(1'b0, 8'd4);
        check("s1_first_idle", pat_valid, 0);
        push(1'b1, 8'd4);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s1_valid_%0d", i), pat_valid, 1);
            check($sformatf("s1_pat_%0d", i), actual_pattern, (i < 4) ? 0 : 1);
            @(negedge clk);
        end
        check("s1_end_valid", pat_valid, 0);
        check("s1_end_pat",   actual_pattern, 1);
        check("s1_bits",      bit_cnt, 8);
        check("s1_runs",      run_cnt, 2);
        check("s1_busy",      busy, 0);

        // Fill the FIFO with playback frozen; the fifth entry waits
        do_reset();
        enable = 1'b0;
        push(1'b1, 8'd1);
        push(1'b0, 8'd1);
        push(1'b1, 8'd1);
        push(1'b0, 8'd1);
        check("s2_full_ready", in_ready, 0);
        in_bit   = 1'b1;
        in_len   = 8'd1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("s2_hold_ready", in_ready, 0);
        check("s2_hold_valid", pat_valid, 0);
        check("s2_hold_bits",  bit_cnt, 0);
        check("s2_hold_busy",  busy, 1);
        enable = 1'b1;
        @(negedge clk);
        check("s2_pop_ready", in_ready, 1);
        check("s2_e1_valid",  pat_valid, 1);
        check("s2_e1_pat",    actual_pattern, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("s2_e2_pat", actual_pattern, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("s2_e%0d_valid", i + 3), pat_valid, 1);
            check($sformatf("s2_e%0d_pat", i + 3), actual_pattern, (i == 1) ? 0 : 1);
        end
        @(negedge clk);
        check("s2_end_valid", pat_valid, 0);
        check("s2_runs",      run_cnt, 5);
        check("s2_bits",      bit_cnt, 5);

        // Zero-length entry between two runs leaves a one-cycle gap
        do_reset();
        push(1'b0, 8'd2);
        check("s3_idle", pat_valid, 0);
        push(1'b1, 8'd0);
        check("s3_b0_valid", pat_valid, 1);
        check("s3_b0_pat",   actual_pattern, 0);
        push(1'b1, 8'd2);
        check("s3_b1_valid", pat_valid, 1);
        check("s3_b1_pat",   actual_pattern, 0);
        @(negedge clk);
        check("s3_gap_valid", pat_valid, 0);
        @(negedge clk);
        check("s3_c0_valid", pat_valid, 1);
        check("s3_c0_pat",   actual_pattern, 1);
        @(negedge clk);
        check("s3_c1_valid", pat_valid, 1);
        check("s3_c1_pat",   actual_pattern, 1);
        @(negedge clk);
        check("s3_end_valid", pat_valid, 0);
        check("s3_runs",      run_cnt, 2);
        check("s3_bits",      bit_cnt, 4);

        // Prediction tied high against {0,3},{1,3}
        do_reset();
        predicted_pattern = 1'b1;
        push(1'b0, 8'd3);
        push(1'b1, 8'd3);
        wait_idle();
        check("s4_miss", miss_cnt, EXP_MISS_S4);
        check("s4_bits", bit_cnt, 6);
        check("s4_runs", run_cnt, 2);
        predicted_pattern = 1'b0;

        // 300 single-cycle runs of 1 against a prediction of 0
        do_reset();
        predicted_pattern = 1'b0;
        for (int i = 0; i < 300; i++) push(1'b1, 8'd1);
        wait_idle();
        check("s5_bits_wrap", bit_cnt, 44);
        check("s5_runs_wrap", run_cnt, 44);
        check("s5_miss_sat",  miss_cnt, EXP_MISS_S5);

        // Freeze mid-run, then reset with three entries queued
        do_reset();
        push(1'b1, 8'd5);
        push(1'b0, 8'd5);
        push(1'b1, 8'd5);
        push(1'b0, 8'd5);
        check("s6_bits_run", bit_cnt, 2);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("s6_freeze_bits",  bit_cnt, 2);
        check("s6_freeze_valid", pat_valid, 0);
        check("s6_freeze_pat",   actual_pattern, 1);
        check("s6_freeze_busy",  busy, 1);
        enable = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("s6_rst_valid", pat_valid, 0);
        check("s6_rst_pat",   actual_pattern, 0);
        check("s6_rst_busy",  busy, 0);
        check("s6_rst_bits",  bit_cnt, 0);
        check("s6_rst_runs",  run_cnt, 0);
        check("s6_rst_miss",  miss_cnt, 0);
        check("s6_rst_ready", in_ready, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("s6_post_valid", pat_valid, 0);
        check("s6_post_busy",  busy, 0);
        check("s6_post_bits",  bit_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
